// File: rtl/div_result_bcd_pkg.sv
// Shared types and constants for the divider result / BCD conversion stage.
package div_result_pkg;

  // FSM states of the result stage
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_CONV  = 2'd2,
    ST_VALID = 2'd3
  } state_t;

  // res_err encodings
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DBZ  = 2'b01;
  localparam logic [1:0] ERR_OV   = 2'b10;

  // BCD digit counts: quotient 0..1023, remainder 0..31
  localparam int Q_DIGITS = 4;
  localparam int R_DIGITS = 2;

  // One binary bit per conversion cycle
  localparam int CONV_CYCLES = 10;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/div_result_bcd_if.sv
// Bundle of divider-side and consumer-side signals of the result stage.
// slave  : the result stage itself
// master : the environment (divider + consumer)
interface div_result_bcd_if
  import div_result_pkg::*;
#(
  parameter int Q_W = 10,
  parameter int R_W = 5
);

  logic                    div_done;
  logic [Q_W-1:0]          div_q;
  logic [Q_W:0]            div_a;
  logic                    div_dbz;
  logic                    div_ov;
  logic                    got_result;
  logic                    res_valid;
  logic                    res_ready;
  logic [4*Q_DIGITS-1:0]   q_bcd;
  logic [4*R_DIGITS-1:0]   r_bcd;
  logic [1:0]              res_err;
  logic                    busy;

  modport slave (
    input  div_done, div_q, div_a, div_dbz, div_ov, res_ready,
    output got_result, res_valid, q_bcd, r_bcd, res_err, busy
  );

  modport master (
    output div_done, div_q, div_a, div_dbz, div_ov, res_ready,
    input  got_result, res_valid, q_bcd, r_bcd, res_err, busy
  );

endinterface

// File: rtl/div_result_bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  // correction applied before each left shift
  always_comb begin
    adj = digit;
    if (digit >= 4'd5) adj = digit + 4'd3;
  end

endmodule

// File: rtl/div_result_bcd.sv
// Result stage of the restoring divider: captures quotient/remainder/flags,
// acknowledges the divider, converts both values to packed BCD one bit per
// cycle and offers the result to the consumer on a valid/ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for div_done; outputs hold the previous result
// ST_ACK   | one-cycle got_result pulse; error check, conversion setup
// ST_CONV  | 10 shift-add-3 steps, quotient and remainder in parallel
// ST_VALID | res_valid high until res_ready
module div_result_bcd
  import div_result_pkg::*;
#(
  parameter int Q_W = 10,
  parameter int R_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  div_result_bcd_if.slave  bus
);

  localparam int QB_W = 4 * Q_DIGITS;
  localparam int RB_W = 4 * R_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [Q_W-1:0]    q_sh;
  logic [Q_W-1:0]    r_sh;
  logic              dbz_l;
  logic              ov_l;
  logic [QB_W-1:0]   q_bcd_r;
  logic [RB_W-1:0]   r_bcd_r;
  logic [1:0]        err_r;
  logic [QB_W-1:0]   q_adj;
  logic [RB_W-1:0]   r_adj;
  logic              unused_a_hi;

  // upper bits of the divider accumulator are not part of the remainder
  assign unused_a_hi = ^bus.div_a[Q_W:R_W];

  // per-digit add-3 correction of the working BCD registers
  for (genvar i = 0; i < Q_DIGITS; i++) begin : g_q_add3
    bcd_add3 u_add3 (
      .digit (q_bcd_r[4*i +: 4]),
      .adj   (q_adj[4*i +: 4])
    );
  end

  for (genvar i = 0; i < R_DIGITS; i++) begin : g_r_add3
    bcd_add3 u_add3 (
      .digit (r_bcd_r[4*i +: 4]),
      .adj   (r_adj[4*i +: 4])
    );
  end

  // state, counter and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      q_sh    <= '0;
      r_sh    <= '0;
      dbz_l   <= 1'b0;
      ov_l    <= 1'b0;
      q_bcd_r <= '0;
      r_bcd_r <= '0;
      err_r   <= ERR_NONE;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (bus.div_done) begin
            q_sh  <= bus.div_q;
            r_sh  <= {{(Q_W-R_W){1'b0}}, bus.div_a[R_W-1:0]};
            dbz_l <= bus.div_dbz;
            ov_l  <= bus.div_ov;
          end
        end
        ST_ACK: begin
          q_bcd_r <= '0;
          r_bcd_r <= '0;
          if (dbz_l) begin
            err_r <= ERR_DBZ;
          end else if (ov_l) begin
            err_r <= ERR_OV;
          end else begin
            err_r <= ERR_NONE;
            cnt   <= CNT_LOAD;
          end
        end
        ST_CONV: begin
          // correct digits, then shift {bcd, binary} left by one
          q_bcd_r <= {q_adj[QB_W-2:0], q_sh[Q_W-1]};
          r_bcd_r <= {r_adj[RB_W-2:0], r_sh[Q_W-1]};
          q_sh    <= {q_sh[Q_W-2:0], 1'b0};
          r_sh    <= {r_sh[Q_W-2:0], 1'b0};
          cnt     <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // next-state logic; div_done and res_ready only matter in their own state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.div_done) state_nxt = ST_ACK;
      ST_ACK:   state_nxt = (dbz_l || ov_l) ? ST_VALID : ST_CONV;
      ST_CONV:  if (cnt == '0) state_nxt = ST_VALID;
      ST_VALID: if (bus.res_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // state-decoded handshake outputs
  always_comb begin
    bus.got_result = (state == ST_ACK);
    bus.res_valid  = (state == ST_VALID);
    bus.busy       = (state != ST_IDLE);
  end

  assign bus.q_bcd   = q_bcd_r;
  assign bus.r_bcd   = r_bcd_r;
  assign bus.res_err = err_r;

endmodule

// File: doc/div_result_bcd.md
# div_result_bcd

Downstream stage of the restoring divider: captures the divider's finished quotient, remainder and error flags, and acknowledges the divider through its `gotResult` input. It converts quotient and remainder to packed BCD with a sequential shift-add-3 (double-dabble) engine. It then presents the result to the display/consumer side over a valid/ready handshake.

## Interface
- `Q_W`, 10: quotient width; matches divider `Q`.
- `R_W`, 5: remainder width; equals the divisor width. Only the defaults are verified.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: reset, synchronous and active-low.
- `div_done`, input, 1: divider `done`; a level held until acknowledged.
- `div_q`, input, 10: divider quotient `Q`.
- `div_a`, input, 11: divider `A`. The remainder is `div_a[4:0]`; `div_a[10:5]` is ignored.
- `div_dbz`, input, 1: divider `divByZero`.
- `div_ov`, input, 1: divider `ov`.
- `got_result`, output, 1: acknowledge to divider `gotResult`; a one-cycle pulse.
- `res_valid`, output, 1: result available.
- `res_ready`, input, 1: consumer accepts the result.
- `q_bcd`, output, 16: 4 BCD digits, quotient 0..1023.
- `r_bcd`, output, 8: 2 BCD digits, remainder 0..31.
- `res_err`, output, 2: 00 ok, 01 divide-by-zero, 10 overflow.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- States: IDLE, ACK, CONV, VALID.
- **IDLE**
  - On an edge with `div_done`=1, latch `div_q`, `div_a[4:0]`, `div_dbz` and `div_ov`; go to ACK.
  - `div_done` is sampled only in IDLE.
- **ACK**, one cycle.
  - `got_result`=1 (registered; high only in this state).
  - Error priority: if `div_dbz`, then `res_err`=01; else if `div_ov`, then `res_err`=10. On either, clear `q_bcd`/`r_bcd` to 0 and go to VALID.
  - Otherwise clear the BCD registers, load the counter with 9, and go to CONV.
- **CONV**, exactly 10 cycles, one binary bit per cycle, MSB first.
  - Each digit ≥5 gets +3, then the whole {BCD, binary} register shifts left by 1.
  - The remainder is zero-extended to 10 bits and converted in parallel with the same counter.
  - Leave to VALID when the counter reaches 0.
- **VALID**
  - `res_valid`=1; `q_bcd`, `r_bcd` and `res_err` are stable.
  - Go to IDLE on an edge with `res_ready`=1; `res_ready` is ignored elsewhere.
- Outputs hold their last values in IDLE and are meaningful only while `res_valid`=1.
- ACK ensures the divider has dropped `done` before IDLE can resample it, so there is no double capture.

## Timing
- Reset (`rst`=0 at any edge, including mid-CONV or in VALID):
  - state goes to IDLE;
  - `got_result`, `res_valid` and `busy` are 0;
  - `q_bcd`, `r_bcd` and `res_err` are 0;
  - any pending result is discarded.
- Capture edge E:
  - `got_result` high in cycle E+1 only.
  - Error path: `res_valid` from cycle E+2.
  - Normal path: `res_valid` from cycle E+12.
- `res_ready` high in the first VALID cycle: `res_valid` lasts exactly 1 cycle and the block is back in IDLE.
- The earliest next capture is 1 cycle after return to IDLE.
- Back-to-back throughput: 13 cycles per result (normal path) with `res_ready` tied high.
- `res_ready`=0 in VALID stalls indefinitely. The divider may already hold a new `done`; it waits until IDLE.
- `div_done` high simultaneously with reset release: captured on the first edge with `rst`=1.

## Structure
- Package `div_result_pkg` holds:
  - the state enum (IDLE/ACK/CONV/VALID);
  - the `res_err` code constants;
  - digit-count constants (4 quotient, 2 remainder);
  - the conversion cycle count (10).
- One natural sub-module, `bcd_add3`: 4-bit digit in, digit+3 out if ≥5, else unchanged.
  - Instantiated 6 times: 4 quotient digits, 2 remainder digits.
- Single always block for state/counter/datapath registers; a combinational FSM next-state block.

## Test plan
- Normal: `div_q`=142, `div_a[4:0]`=6, no flags, `res_ready`=1 → `got_result` pulse at E+1; `res_valid` at E+12; `q_bcd`=16'h0142, `r_bcd`=8'h06, `res_err`=00.
- Corner values: `div_q`=1023 with remainder 31, then `div_q`=0 with remainder 0 → 16'h1023/8'h31, then 16'h0000/8'h00, each at E+12.
- Errors:
  - `div_dbz`=1 → `res_err`=01, zero BCD, `res_valid` at E+2.
  - `div_dbz`=1 and `div_ov`=1 together → `res_err`=01 (divide-by-zero wins).
  - `div_ov` only → `res_err`=10.
- Backpressure: hold `res_ready`=0 for 20 cycles in VALID while `div_done` stays high → outputs stable, `got_result` stays 0, no capture. Release → IDLE, then new capture and a single `got_result` pulse.
- Reset mid-CONV: drive `rst`=0 at E+6 → next cycle IDLE with all outputs 0. A subsequent capture of 999 r 30 yields 16'h0999/8'h30.
- Held `done`: `div_done` held high for 3 cycles after `got_result` → exactly one capture, one `res_valid` episode.
